// File: rtl/reg_port_arbiter.sv
// Purpose : round-robin arbiter sharing the register file between CPU (port 0) and NPU (port 1);
//           each grant runs one dual write or one quad read against the register file.
// Latency : 3 cycles per transaction (IDLE grant edge -> WRITE/READ -> DONE with ack pulse).
// Backpr. : requesters hold req_i until their ack_o; requests and fields are sampled only in IDLE.
// Ports   : clk_i/rst_i           clock, async active-high reset
//           req_i/we_i            per-requester request and op (1 = dual write, 0 = quad read)
//           waddr_i/wdata_i       {req1{a2,a1},req0{a2,a1}} write addresses / {.. {d2,d1}} data
//           raddr_i               {req1{a4..a1},req0{a4..a1}} read addresses
//           ack_o/rdata_o/busy_o  completion pulse, {d4..d1} read data on read ack, non-IDLE flag
//           en_w_reg_o, w_reg_addr_o, w_reg_data_o, r_reg_addr_o, r_reg_data_i  register file side
module reg_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          req_i,
  input  logic [1:0]          we_i,
  input  logic [4*ADDR_W-1:0] waddr_i,
  input  logic [4*DATA_W-1:0] wdata_i,
  input  logic [8*ADDR_W-1:0] raddr_i,
  output logic [1:0]          ack_o,
  output logic [4*DATA_W-1:0] rdata_o,
  output logic                busy_o,
  output logic                en_w_reg_o,
  output logic [2*ADDR_W-1:0] w_reg_addr_o,
  output logic [2*DATA_W-1:0] w_reg_data_o,
  output logic [4*ADDR_W-1:0] r_reg_addr_o,
  input  logic [4*DATA_W-1:0] r_reg_data_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_last_gnt;
  logic                r_sel;
  logic [1:0]          r_ack;
  logic                r_busy;
  logic                r_en_w;
  logic                r_rd_pass;
  logic [2*ADDR_W-1:0] r_w_addr;
  logic [2*DATA_W-1:0] r_w_data;
  logic [4*ADDR_W-1:0] r_r_addr;

  logic                w_any_req;
  logic                w_sel;
  logic                w_we;
  logic [2*ADDR_W-1:0] w_waddr;
  logic [2*DATA_W-1:0] w_wdata;
  logic [4*ADDR_W-1:0] w_raddr;

  // With both requesting, the one not granted last time wins; otherwise the sole requester.
  assign w_any_req = |req_i;
  assign w_sel     = (&req_i) ? ~r_last_gnt : req_i[1];
  assign w_we      = w_sel ? we_i[1] : we_i[0];
  assign w_waddr   = w_sel ? waddr_i[4*ADDR_W-1:2*ADDR_W] : waddr_i[2*ADDR_W-1:0];
  assign w_wdata   = w_sel ? wdata_i[4*DATA_W-1:2*DATA_W] : wdata_i[2*DATA_W-1:0];
  assign w_raddr   = w_sel ? raddr_i[8*ADDR_W-1:4*ADDR_W] : raddr_i[4*ADDR_W-1:0];

  // The output registers double as the latched transaction fields: they are loaded on the
  // grant edge and cleared when leaving the state that drives them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_last_gnt <= 1'b1;
      r_sel      <= 1'b0;
      r_ack      <= 2'b00;
      r_busy     <= 1'b0;
      r_en_w     <= 1'b0;
      r_rd_pass  <= 1'b0;
      r_w_addr   <= '0;
      r_w_data   <= '0;
      r_r_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel      <= w_sel;
            r_last_gnt <= w_sel;
            r_busy     <= 1'b1;
            if (w_we) begin
              r_state  <= S_WRITE;
              r_en_w   <= 1'b1;
              r_w_addr <= w_waddr;
              r_w_data <= w_wdata;
            end else begin
              r_state  <= S_READ;
              r_r_addr <= w_raddr;
            end
          end
        end
        S_WRITE: begin
          // Register file commits on this closing edge; a1==a2 leaves d2 in place.
          r_state  <= S_DONE;
          r_en_w   <= 1'b0;
          r_w_addr <= '0;
          r_w_data <= '0;
          r_ack    <= {r_sel, ~r_sel};
        end
        S_READ: begin
          // Register file captures its read data on this closing edge.
          r_state   <= S_DONE;
          r_r_addr  <= '0;
          r_rd_pass <= 1'b1;
          r_ack     <= {r_sel, ~r_sel};
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_ack     <= 2'b00;
          r_rd_pass <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack_o        = r_ack;
  assign busy_o       = r_busy;
  assign en_w_reg_o   = r_en_w;
  assign w_reg_addr_o = r_w_addr;
  assign w_reg_data_o = r_w_data;
  assign r_reg_addr_o = r_r_addr;
  // Read data is passed straight through during the DONE cycle of a read only.
  assign rdata_o      = r_rd_pass ? r_reg_data_i : '0;

endmodule
